// File: rtl/data_sram_resp_if.sv
`default_nettype none
// ============================================================================
// data_sram_resp_if : data-side SRAM-like bus (req/addr_ok, data_ok/rdata)
// Rev 1.0
// ============================================================================
interface data_sram_resp_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, addr, wstrb, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wstrb, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface
`default_nettype wire

// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
// data_sram_resp : fixed-latency, in-order responder backed by a byte-strobed word memory
// Rev 1.0
// ============================================================================
module data_sram_resp #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 2,
   parameter int unsigned QDEPTH  = 4
) (
   input wire              clk,
   input wire              resetn,
   data_sram_resp_if.slave bus
);

   localparam int unsigned     c_PW         = $clog2(QDEPTH);
   localparam int unsigned     c_TW         = 4;
   localparam logic [c_TW-1:0] c_TIMER_INIT = c_TW'(LATENCY - 1);
   localparam logic [c_PW:0]   c_FULL       = (c_PW + 1)'(QDEPTH);

   logic [31:0]       r_mem [0:(1 << ADDR_W) - 1];
   logic [QDEPTH-1:0] r_valid;
   logic              r_is_load [QDEPTH];
   logic [31:0]       r_data    [QDEPTH];
   logic [c_TW-1:0]   r_timer   [QDEPTH];
   logic [c_PW-1:0]   r_wptr;
   logic [c_PW-1:0]   r_rptr;
   logic [c_PW:0]     r_count;

   logic [ADDR_W-1:0] w_idx;
   logic              w_addr_ok;
   logic              w_data_ok;
   logic              w_push;
   logic              w_pop;
   logic              w_unused;

   assign w_idx     = bus.addr[ADDR_W+1:2];
   assign w_addr_ok = resetn & (r_count < c_FULL);
   assign w_data_ok = resetn & r_valid[r_rptr] & (r_timer[r_rptr] == '0);
   assign w_push    = bus.req & w_addr_ok;
   assign w_pop     = w_data_ok;
   assign w_unused  = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0]};

   assign bus.addr_ok = w_addr_ok;
   assign bus.data_ok = w_data_ok;
   assign bus.rdata   = (w_data_ok && r_is_load[r_rptr]) ? r_data[r_rptr] : 32'h0;

   // Memory is deliberately not reset; writes that completed before a reset persist.
   always_ff @(posedge clk) begin
      if (w_push && bus.wr) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.wstrb[i]) begin
               r_mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_is_load[r_wptr] <= ~bus.wr;
         r_data[r_wptr]    <= bus.wr ? 32'h0 : r_mem[w_idx];
      end
   end

   // A push never lands on the head slot: it needs count < QDEPTH, and a pop needs count > 0.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_valid <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            r_timer[i] <= '0;
         end
      end else begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (r_valid[i] && (r_timer[i] != '0)) begin
               r_timer[i] <= r_timer[i] - c_TW'(1);
            end
         end
         if (w_pop) begin
            r_valid[r_rptr] <= 1'b0;
            r_rptr          <= r_rptr + c_PW'(1);
         end
         if (w_push) begin
            r_valid[r_wptr] <= 1'b1;
            r_timer[r_wptr] <= c_TIMER_INIT;
            r_wptr          <= r_wptr + c_PW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (c_PW + 1)'(1);
            2'b01:   r_count <= r_count - (c_PW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// ============================================================================
// tb_data_sram_resp : scoreboard bench over four configurations of data_sram_resp
// Rev 1.0
// ============================================================================
module tb_data_sram_resp;

   localparam int LAT [4] = '{2, 2, 1, 4};

   typedef struct {
      int          k;
      int unsigned cyc;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   int unsigned cyc = 0;
   int          n_pass = 0;
   int          n_total = 0;
   exp_t        sb [$];

   logic        req_d   [4];
   logic        wr_d    [4];
   logic [31:0] addr_d  [4];
   logic [3:0]  wstrb_d [4];
   logic [31:0] wdata_d [4];
   logic        aok [4];
   logic        dok [4];
   logic [31:0] rd  [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_sram_resp_if bus0 ();
   data_sram_resp_if bus1 ();
   data_sram_resp_if bus2 ();
   data_sram_resp_if bus3 ();

`define TB_CONN(B, K) \
   assign B.req = req_d[K]; assign B.wr = wr_d[K]; assign B.size = 2'd2; \
   assign B.addr = addr_d[K]; assign B.wstrb = wstrb_d[K]; assign B.wdata = wdata_d[K]; \
   assign aok[K] = B.addr_ok; assign dok[K] = B.data_ok; assign rd[K] = B.rdata;

   `TB_CONN(bus0, 0)
   `TB_CONN(bus1, 1)
   `TB_CONN(bus2, 2)
   `TB_CONN(bus3, 3)
`undef TB_CONN

   data_sram_resp #(.ADDR_W(10), .LATENCY(2), .QDEPTH(4)) u_main (.clk(clk), .resetn(resetn), .bus(bus0));
   data_sram_resp #(.ADDR_W(10), .LATENCY(2), .QDEPTH(2)) u_q2   (.clk(clk), .resetn(resetn), .bus(bus1));
   data_sram_resp #(.ADDR_W(10), .LATENCY(1), .QDEPTH(4)) u_l1   (.clk(clk), .resetn(resetn), .bus(bus2));
   data_sram_resp #(.ADDR_W(10), .LATENCY(4), .QDEPTH(4)) u_l4   (.clk(clk), .resetn(resetn), .bus(bus3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every data_ok must match the oldest expectation for that instance, in data and cycle.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (dok[k]) begin
            int idx;
            idx = -1;
            foreach (sb[j]) if (idx < 0 && sb[j].k == k) idx = j;
            if (idx < 0) begin
               chk($sformatf("unexpected_data_ok_%0d", k), {31'b0, dok[k]}, 32'h0);
            end else begin
               chk($sformatf("rdata_%0d", k), rd[k], sb[idx].data);
               chk($sformatf("resp_cycle_%0d", k), cyc, sb[idx].cyc);
               sb.delete(idx);
            end
         end else if (rd[k] !== 32'h0) begin
            chk($sformatf("idle_rdata_%0d", k), rd[k], 32'h0);
         end
      end
   end

   task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp);
      req_d[k] = 1'b1; wr_d[k] = w; addr_d[k] = a; wstrb_d[k] = s; wdata_d[k] = d;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (aok[k]) begin
            sb.push_back('{k, cyc + LAT[k], exp});
            @(posedge clk); #1;
            req_d[k] = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      chk("accept_timeout", {31'b0, aok[k]}, 32'h1);
      req_d[k] = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
      chk("drain", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         req_d[k] = 1'b0; wr_d[k] = 1'b0; addr_d[k] = '0; wstrb_d[k] = '0; wdata_d[k] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_addr_ok", {31'b0, aok[0]}, 32'h0);
      chk("reset_data_ok", {31'b0, dok[0]}, 32'h0);
      chk("reset_rdata", rd[0], 32'h0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) chk($sformatf("post_reset_addr_ok_%0d", k), {31'b0, aok[k]}, 32'h1);
      @(posedge clk); #1;

      // Basic load latency, then partial-strobe store followed by a dependent load
      issue(0, 1'b1, 32'h40, 4'hF, 32'h11223344, 32'h0);
      drain();
      issue(0, 1'b0, 32'h40, 4'h0, 32'h0, 32'h11223344);
      drain();
      issue(0, 1'b1, 32'h40, 4'b0101, 32'hAABBCCDD, 32'h0);
      issue(0, 1'b0, 32'h40, 4'h0, 32'h0, 32'h11BB33DD);
      drain();

      // Address aliasing, ignored low bits, zero-strobe store
      issue(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 32'h0);
      issue(0, 1'b0, 32'h1000, 4'h0, 32'h0, 32'hCAFEF00D);
      issue(0, 1'b0, 32'h43, 4'h0, 32'h0, 32'h11BB33DD);
      issue(0, 1'b1, 32'h40, 4'h0, 32'hFFFFFFFF, 32'h0);
      issue(0, 1'b0, 32'h40, 4'h0, 32'h0, 32'h11BB33DD);
      drain();

      // QDEPTH=2, LATENCY=2: held req throttles as 1,1,0,1,1,0
      for (int i = 0; i < 6; i++) issue(1, 1'b1, 32'h100 + 32'(4*i), 4'hF, 32'hB000_0000 + 32'(i), 32'h0);
      drain();
      begin
         logic [5:0] pat;
         int acc;
         pat = 6'b011011;
         acc = 0;
         req_d[1] = 1'b1; wr_d[1] = 1'b0; addr_d[1] = 32'h100;
         for (int c = 0; c < 30 && acc < 6; c++) begin
            @(negedge clk);
            if (c < 6) chk($sformatf("q2_addr_ok_c%0d", c), {31'b0, aok[1]}, {31'b0, pat[c]});
            if (aok[1]) begin
               sb.push_back('{1, cyc + LAT[1], 32'hB000_0000 + 32'(acc)});
               acc++;
            end
            @(posedge clk); #1;
            addr_d[1] = 32'h100 + 32'(4*acc);
         end
         req_d[1] = 1'b0;
         chk("q2_accepted", acc, 6);
      end
      drain();

      // LATENCY=1: back-to-back loads, addr_ok never drops, pointers wrap twice
      for (int i = 0; i < 8; i++) issue(2, 1'b1, 32'(4*i), 4'hF, 32'hA000_0000 + 32'(i), 32'h0);
      drain();
      req_d[2] = 1'b1; wr_d[2] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         addr_d[2] = 32'(4*i);
         @(negedge clk);
         chk($sformatf("l1_addr_ok_%0d", i), {31'b0, aok[2]}, 32'h1);
         if (aok[2]) sb.push_back('{2, cyc + LAT[2], 32'hA000_0000 + 32'(i)});
         @(posedge clk); #1;
      end
      req_d[2] = 1'b0;
      drain();

      // Reset with three loads outstanding: none answered, earlier store persists
      issue(3, 1'b1, 32'h80, 4'hF, 32'h5EED5EED, 32'h0);
      drain();
      for (int i = 0; i < 3; i++) issue(3, 1'b0, 32'h80, 4'h0, 32'h0, 32'h5EED5EED);
      resetn = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("mid_reset_addr_ok", {31'b0, aok[3]}, 32'h0);
      chk("mid_reset_data_ok", {31'b0, dok[3]}, 32'h0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("after_reset_addr_ok", {31'b0, aok[3]}, 32'h1);
      repeat (8) @(posedge clk);
      #1;
      issue(3, 1'b0, 32'h80, 4'h0, 32'h0, 32'h5EED5EED);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
